// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx                                                       |
// | Purpose  : 16x-oversampling UART receiver, LSB-first, feeds the RX fifo. |
// |            Optional parity stage enabled by `define UART_RX_PARITY_EN.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Stop-bit spans above 16 ticks need a wider tick counter.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

  localparam logic [NW-1:0] c_n_last = NW'(DBIT - 1);
  localparam logic [SW-1:0] c_s_mid  = SW'(7);
  localparam logic [SW-1:0] c_s_bit  = SW'(15);
  localparam logic [SW-1:0] c_s_stop = SW'(SB_TICK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_rx_meta;
  logic            r_rxs;
  logic            r_rxp;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;

`ifdef UART_RX_PARITY_EN
  localparam logic c_parity_odd = (PARITY_ODD != 0);
  logic r_perr;
  logic r_perr_out;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxp     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
      r_rxp     <= r_rxs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr     <= 1'b0;
      r_perr_out <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_out <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // Edge-triggered start so a line stuck low cannot re-arm the receiver.
          if (r_rxp && !r_rxs) begin
            r_state <= START;
            r_s     <= '0;
          end
        end

        START: begin
          if (s_tick) begin
            if (r_s == c_s_mid) begin
              if (!r_rxs) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (r_s == c_s_bit) begin
              r_b <= {r_rxs, r_b[DBIT-1:1]};
              r_s <= '0;
              if (r_n == c_n_last) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (r_s == c_s_bit) begin
              r_perr  <= (^r_b) ^ r_rxs ^ c_parity_odd;
              r_s     <= '0;
              r_state <= STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (s_tick) begin
            if (r_s == c_s_stop) begin
              r_state <= IDLE;
              if (r_rxs) begin
                r_dout <= r_b;
                r_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                r_perr_out <= r_perr;
`endif
              end else begin
                r_ferr <= 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_ferr;

`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr_out;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
  assign parity_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                    |
// | Purpose  : Directed self-checking bench for uart_rx (8 data bits, 1 stop)|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx      = 1'b1;
  logic       s_tick  = 1'b0;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  int         done_cnt  = 0;
  int         ferr_cnt  = 0;
  int         perr_cnt  = 0;
  int         both_cnt  = 0;
  int         tick_div  = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_perr = 1'b0;

  int d0;
  int f0;

  uart_rx #(
    .DBIT       (8),
    .SB_TICK    (16),
    .PARITY_ODD (0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge, then advance the tick strobe for the next rising edge.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt  = done_cnt + 1;
      last_dout = dout;
      last_perr = parity_err;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (parity_err) perr_cnt = perr_cnt + 1;
    if (rx_done_tick && frame_err) both_cnt = both_cnt + 1;
    s_tick   = (tick_div == 3);
    tick_div = (tick_div + 1) % 4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bits(input logic b, input int nbits);
    rx = b;
    repeat (nbits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    hold_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) hold_bits(d[i], 1);
`ifdef UART_RX_PARITY_EN
    hold_bits(par_bit, 1);
`endif
    hold_bits(stop_bit, 1);
    hold_bits(1'b1, 2);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_done", {31'd0, rx_done_tick}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_perr", {31'd0, parity_err}, 32'd0);
    chk("reset_dout", {24'd0, dout}, 32'h00);
    reset_n = 1'b1;
    hold_bits(1'b1, 2);

    // 1: clean frame
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("t1_done_cnt", done_cnt - d0, 32'd1);
    chk("t1_dout", {24'd0, last_dout}, 32'hA5);
    chk("t1_ferr_cnt", ferr_cnt - f0, 32'd0);

    // 2: short start glitch (4 ticks)
    d0 = done_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    hold_bits(1'b1, 12);
    chk("t2_done_cnt", done_cnt - d0, 32'd0);
    chk("t2_ferr_cnt", ferr_cnt - f0, 32'd0);

    // 3: bad stop bit
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("t3_ferr_cnt", ferr_cnt - f0, 32'd1);
    chk("t3_done_cnt", done_cnt - d0, 32'd0);
    chk("t3_dout_kept", {24'd0, dout}, 32'hA5);

    // 4: break then a good frame
    d0 = done_cnt; f0 = ferr_cnt;
    hold_bits(1'b0, 40);
    chk("t4_break_ferr", ferr_cnt - f0, 32'd1);
    hold_bits(1'b1, 2);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("t4_ferr_total", ferr_cnt - f0, 32'd1);
    chk("t4_done_cnt", done_cnt - d0, 32'd1);
    chk("t4_dout", {24'd0, last_dout}, 32'h5A);

    // 5: reset in the middle of data bit 3
    d0 = done_cnt; f0 = ferr_cnt;
    hold_bits(1'b0, 1);
    hold_bits(1'b1, 1);
    hold_bits(1'b0, 1);
    hold_bits(1'b1, 1);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hold_bits(1'b1, 3);
    chk("t5_abort_done", done_cnt - d0, 32'd0);
    chk("t5_abort_ferr", ferr_cnt - f0, 32'd0);
    chk("t5_dout_reset", {24'd0, dout}, 32'h00);
    send_frame(8'hFF, 1'b0, 1'b1);
    chk("t5_done_cnt", done_cnt - d0, 32'd1);
    chk("t5_dout", {24'd0, last_dout}, 32'hFF);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, 0x07 has three ones
    d0 = done_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    chk("t6a_done_cnt", done_cnt - d0, 32'd1);
    chk("t6a_dout", {24'd0, last_dout}, 32'h07);
    chk("t6a_perr", {31'd0, last_perr}, 32'd1);
    d0 = done_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("t6b_done_cnt", done_cnt - d0, 32'd1);
    chk("t6b_perr", {31'd0, last_perr}, 32'd0);
`else
    chk("no_parity_pulses", perr_cnt, 32'd0);
`endif

    chk("done_ferr_exclusive", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
